// File: rtl/csub_seq_if.sv
// csub_seq_if: request/result bundle for the sequential carry-select subtractor
interface csub_seq_if #(
    parameter int W = 32
);
    logic         start;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;

    modport master (output start, x, y, bin, input busy, done, d, bout, ovf);
    modport slave  (input start, x, y, bin, output busy, done, d, bout, ovf);
endinterface

// File: rtl/csub_seq.sv
// csub_seq: multi-cycle carry-select subtractor, CHUNK bits of x - y - bin per clock
module csub_seq #(
    parameter int W     = 32,
    parameter int CHUNK = 8
) (
    input logic       clk,
    input logic       rst,
    csub_seq_if.slave bus
);
    localparam int N  = W / CHUNK;
    localparam int CW = N > 1 ? $clog2(N) : 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             brw;
    logic [W-1:0]     xr;
    logic [W-1:0]     yr;
    logic [W-1:0]     dr;
    logic             bout_r;
    logic             ovf_r;
    logic [CHUNK-1:0] xc;
    logic [CHUNK-1:0] yc;
    logic [CHUNK:0]   cand0;
    logic [CHUNK:0]   cand1;
    logic [CHUNK:0]   sel;
    logic             last;
    logic             accept;

    // both borrow-in candidates for the current chunk, picked by the registered borrow
    always_comb begin
        xc     = xr[cnt*CHUNK +: CHUNK];
        yc     = yr[cnt*CHUNK +: CHUNK];
        cand1  = {1'b0, xc} + {1'b0, ~yc};
        cand0  = cand1 + (CHUNK+1)'(1);
        sel    = brw ? cand1 : cand0;
        last   = cnt == CW'(N - 1);
        accept = (state != RUN) && bus.start;
    end

    // operand capture, chunk sequencing and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            brw    <= 1'b0;
            xr     <= '0;
            yr     <= '0;
            dr     <= '0;
            bout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (accept) begin
            state  <= RUN;
            cnt    <= '0;
            brw    <= bus.bin;
            xr     <= bus.x;
            yr     <= bus.y;
            dr     <= '0;
            bout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (state == RUN) begin
            dr[cnt*CHUNK +: CHUNK] <= sel[CHUNK-1:0];
            brw <= ~sel[CHUNK];
            cnt <= cnt + CW'(1);
            if (last) begin
                state  <= DONE;
                bout_r <= ~sel[CHUNK];
                ovf_r  <= (xr[W-1] != yr[W-1]) && (sel[CHUNK-1] != xr[W-1]);
            end
        end else begin
            state <= IDLE;
        end
    end

    assign bus.busy = state == RUN;
    assign bus.done = state == DONE;
    assign bus.d    = dr;
    assign bus.bout = bout_r;
    assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_csub_seq.sv
// tb_csub_seq: scoreboard bench for csub_seq (W=32, CHUNK=8)
module tb_csub_seq;
    typedef struct packed {
        logic [31:0] d;
        logic        bout;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    exp_t q[$];

    csub_seq_if #(.W(32)) bus ();
    csub_seq #(.W(32), .CHUNK(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    // drive a request at the current (negedge) time and record its reference result
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic c);
        logic [32:0] r;
        bus.start = 1'b1;
        bus.x     = a;
        bus.y     = b;
        bus.bin   = c;
        r = {1'b0, a} - {1'b0, b} - {32'd0, c};
        q.push_back({r[31:0], r[32], (a[31] != b[31]) && (r[31] != a[31])});
    endtask

    // wait for done with a bounded budget, then pop and compare
    task automatic wait_check(input int n0);
        exp_t e;
        int n = n0;
        while (!bus.done && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!bus.done) begin
            errors++;
            $display("FAIL done_timeout: waited %0d edges", n);
        end else if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: at %0d edges, queue empty", n);
        end else begin
            e = q.pop_front();
            if (n !== 5) begin
                errors++;
                $display("FAIL latency: got %0d edges, expected 5", n);
            end
            checks++;
            if (bus.d !== e.d) begin
                errors++;
                $display("FAIL d: got %h, expected %h", bus.d, e.d);
            end
            checks++;
            if (bus.bout !== e.bout) begin
                errors++;
                $display("FAIL bout: got %b, expected %b", bus.bout, e.bout);
            end
            checks++;
            if (bus.ovf !== e.ovf) begin
                errors++;
                $display("FAIL ovf: got %b, expected %b", bus.ovf, e.ovf);
            end
        end
    endtask

    // drop start after the accepting edge, scramble inputs, and collect the result
    task automatic finish_op();
        @(negedge clk);
        bus.start = 1'b0;
        bus.x     = $urandom;
        bus.y     = $urandom;
        bus.bin   = 1'($urandom);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_accept: got %b, expected 1", bus.busy);
        end
        wait_check(1);
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.x     = '0;
        bus.y     = '0;
        bus.bin   = 1'b0;
        rst       = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.d, bus.bout, bus.ovf} !== 35'd0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b d=%h bout=%b ovf=%b, expected all 0",
                     bus.busy, bus.done, bus.d, bus.bout, bus.ovf);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        launch(32'd100, 32'd58, 1'b0);
        finish_op();
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.d !== 32'd42) begin
            errors++;
            $display("FAIL hold_after_done: got done=%b busy=%b d=%h, expected 0 0 0000002a",
                     bus.done, bus.busy, bus.d);
        end
        launch(32'd0, 32'd1, 1'b0);
        finish_op();
        launch(32'h8000_0000, 32'd1, 1'b0);
        finish_op();
        launch(32'h0000_0100, 32'h0000_00FF, 1'b1);
        finish_op();
        launch(32'd0, 32'd0, 1'b1);
        finish_op();
        launch(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        finish_op();
        launch(32'h0100_0000, 32'h0000_0000, 1'b1);
        finish_op();
        @(negedge clk);
    endtask

    task automatic test_start_in_run();
        launch(32'd100, 32'd58, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.x     = 32'd5;
        bus.y     = 32'd1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_check(3);
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || q.size() != 0) begin
            errors++;
            $display("FAIL start_in_run_ignored: got busy=%b done=%b pending=%0d, expected 0 0 0",
                     bus.busy, bus.done, q.size());
        end
    endtask

    task automatic test_reset_mid_run();
        launch(32'hFFFF_FFFF, 32'd0, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.d !== 32'h0000_FFFF || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL partial_fill: got d=%h busy=%b, expected 0000ffff 1", bus.d, bus.busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.d, bus.bout, bus.ovf} !== 35'd0) begin
            errors++;
            $display("FAIL async_reset: got busy=%b done=%b d=%h bout=%b ovf=%b, expected all 0",
                     bus.busy, bus.done, bus.d, bus.bout, bus.ovf);
        end
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL aborted_no_done: got done=%b busy=%b, expected 0 0", bus.done, bus.busy);
        end
        launch(32'd7, 32'd3, 1'b0);
        finish_op();
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        launch(32'd1000, 32'd1, 1'b1);
        finish_op();
        launch(32'd10, 32'd20, 1'b0);
        finish_op();
        launch(32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
        finish_op();
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 400; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: a = b;
                1: a = 32'hFFFF_FFFF;
                2: b = 32'hFFFF_FFFF;
                3: a = {a[31:8], 8'h00};
                default: ;
            endcase
            launch(a, b, 1'($urandom));
            finish_op();
            if ($urandom_range(0, 2) == 0) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_in_run();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
